// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters, predicting next-PC beside IF.
// Optional performance counters are built only when BRANCH_PREDICTOR_PERF_CNT_EN is defined.
module branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             flush_i,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [XLEN-1:0]  upd_pred_target_i,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;

    localparam logic [CTR_W-1:0] CtrMax    = '1;
    localparam logic [CTR_W-1:0] CtrWeakT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CtrWeakNt = CtrWeakT - CTR_W'(1);

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];
    logic [CTR_W-1:0] ctr_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    always_comb begin
        lk_idx        = if_pc_i[IDX_W+1:2];
        lk_tag        = if_pc_i[TAG_LO+TAG_W-1:TAG_LO];
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
        pred_target_o = pred_taken_o ? target_q[lk_idx] : if_pc_i + XLEN'(4);
    end

    always_comb begin
        up_idx        = upd_pc_i[IDX_W+1:2];
        up_tag        = upd_pc_i[TAG_LO+TAG_W-1:TAG_LO];
        up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        mispredict_o  = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));
        redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        ctr_d    = ctr_q;
        target_d = target_q;
        if (flush_i) begin
            // Only valid bits are cleared; stale ctr/target are unreachable until reallocated.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    if (ctr_q[up_idx] != CtrMax) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                    end
                    target_d[up_idx] = upd_target_i;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                ctr_d[up_idx]    = CtrWeakT;
                target_d[up_idx] = upd_target_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CtrWeakNt;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            ctr_q    <= ctr_d;
            target_q <= target_d;
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d;

    // Counters ignore flush_i and stick at all-ones.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid_i && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict_o && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor at default parameters; counter expectations
// follow BRANCH_PREDICTOR_PERF_CNT_EN.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        flush_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_target_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .if_pc_i           (if_pc_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .flush_i           (flush_i),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int n);
`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
        return 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt,
                       input logic ptkn, input logic [31:0] ptgt);
        upd_valid_i       = 1'b1;
        upd_pc_i          = pc;
        upd_taken_i       = tkn;
        upd_target_i      = tgt;
        upd_pred_taken_i  = ptkn;
        upd_pred_target_i = ptgt;
    endtask

    initial begin
        rst_i = 1'b0;
        if_pc_i = 32'h40;
        flush_i = 1'b0;
        upd_valid_i = 1'b0;
        upd_pc_i = '0;
        upd_taken_i = 1'b0;
        upd_target_i = '0;
        upd_pred_taken_i = 1'b0;
        upd_pred_target_i = '0;
        repeat (2) tick();
        rst_i = 1'b1;
        #1;
        chk("rst_pred_taken", pred_taken_o, 0);
        chk("rst_pred_target", pred_target_o, 32'h44);
        chk("rst_branch_cnt", branch_cnt_o, ec(0));
        chk("rst_mispred_cnt", mispred_cnt_o, ec(0));

        // Allocate 0x40 while looking it up in the same cycle
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        chk("alloc_mispredict", mispredict_o, 1);
        chk("alloc_redirect", redirect_pc_o, 32'h80);
        chk("same_cycle_pred_taken", pred_taken_o, 0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("after_alloc_taken", pred_taken_o, 1);
        chk("after_alloc_target", pred_target_o, 32'h80);
        chk("after_alloc_bcnt", branch_cnt_o, ec(1));
        chk("after_alloc_mcnt", mispred_cnt_o, ec(1));

        // Four not-taken: ctr 2->1->0->0->0
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk("nt_redirect", redirect_pc_o, 32'h44);
        chk("nt_mispredict", mispredict_o, 1);
        tick();
        repeat (3) tick();
        upd_valid_i = 1'b0;
        #1;
        chk("sat0_pred_taken", pred_taken_o, 0);
        chk("sat0_pred_target", pred_target_o, 32'h44);
        chk("sat0_bcnt", branch_cnt_o, ec(5));
        chk("sat0_mcnt", mispred_cnt_o, ec(5));

        // Five taken: ctr 0->1->2->3->3->3, correct prediction each time
        upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk("t_no_mispredict", mispredict_o, 0);
        repeat (5) tick();
        upd_valid_i = 1'b0;
        #1;
        chk("sat3_pred_taken", pred_taken_o, 1);
        chk("sat3_pred_target", pred_target_o, 32'h80);
        chk("sat3_bcnt", branch_cnt_o, ec(10));
        chk("sat3_mcnt", mispred_cnt_o, ec(5));

        // One not-taken from 3 -> 2, still predicts taken
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("ctr2_pred_taken", pred_taken_o, 1);

        // Wrong target with right direction
        upd(32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
        #1;
        chk("tgt_mispredict", mispredict_o, 1);
        chk("tgt_redirect", redirect_pc_o, 32'hC0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("tgt_updated", pred_target_o, 32'hC0);
        chk("tgt_mispredict_gated", mispredict_o, 0);
        chk("tgt_bcnt", branch_cnt_o, ec(12));
        chk("tgt_mcnt", mispred_cnt_o, ec(7));

        // Aliasing: 0x440 shares index 0 with 0x40
        upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("alias_old_taken", pred_taken_o, 0);
        chk("alias_old_target", pred_target_o, 32'h44);
        if_pc_i = 32'h440;
        #1;
        chk("alias_new_taken", pred_taken_o, 1);
        chk("alias_new_target", pred_target_o, 32'h200);

        // Miss, not-taken: no allocation
        upd(32'h48, 1'b0, 32'h100, 1'b0, 32'h4C);
        #1;
        chk("mnt_mispredict", mispredict_o, 0);
        chk("mnt_redirect", redirect_pc_o, 32'h4C);
        tick();
        upd_valid_i = 1'b0;
        if_pc_i = 32'h48;
        #1;
        chk("mnt_no_alloc", pred_taken_o, 0);
        chk("mnt_bcnt", branch_cnt_o, ec(14));
        chk("mnt_mcnt", mispred_cnt_o, ec(8));

        // Flush beats a taken allocation but counters still count
        flush_i = 1'b1;
        upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
        #1;
        chk("flush_mispredict", mispredict_o, 1);
        tick();
        flush_i = 1'b0;
        upd_valid_i = 1'b0;
        if_pc_i = 32'h440;
        #1;
        chk("flush_old_taken", pred_taken_o, 0);
        chk("flush_old_target", pred_target_o, 32'h444);
        if_pc_i = 32'h80;
        #1;
        chk("flush_no_alloc", pred_taken_o, 0);
        chk("flush_bcnt", branch_cnt_o, ec(15));
        chk("flush_mcnt", mispred_cnt_o, ec(9));

        // +4 wraps
        if_pc_i = 32'hFFFF_FFFC;
        upd_pc_i = 32'hFFFF_FFFC;
        upd_taken_i = 1'b0;
        #1;
        chk("wrap_pred_target", pred_target_o, 32'h0);
        chk("wrap_redirect", redirect_pc_o, 32'h0);

        // Mid-stream reset, with an update that must be discarded
        if_pc_i = 32'h40;
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("pre_rst_taken", pred_taken_o, 1);
        chk("pre_rst_bcnt", branch_cnt_o, ec(16));
        rst_i = 1'b0;
        upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
        #1;
        chk("rst_cycle_mispredict", mispredict_o, 1);
        tick();
        rst_i = 1'b1;
        upd_valid_i = 1'b0;
        #1;
        chk("post_rst_taken", pred_taken_o, 0);
        chk("post_rst_target", pred_target_o, 32'h44);
        chk("post_rst_bcnt", branch_cnt_o, ec(0));
        chk("post_rst_mcnt", mispred_cnt_o, ec(0));
        if_pc_i = 32'h440;
        #1;
        chk("post_rst_discard", pred_taken_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor with a direct-mapped, tagged branch target buffer and saturating per-entry direction counters, for the 5-stage pipelined core. It sits beside the IF stage and predicts next-PC in the same cycle as instruction fetch. It is trained by branch resolution in ID and reports mispredictions so ID can flush IF/ID and redirect the PC. It replaces the current scheme, where every taken branch costs a flush.

## Interface
Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, BTB entry count; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8, stored tag bits; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2]
- CTR_W, 2, direction counter width, ≥1
- CNT_W, 32, performance counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-low
- if_pc_i  in  XLEN  fetch PC for lookup
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  XLEN  predicted next PC
- flush_i  in  1  invalidate all entries
- upd_valid_i  in  1  resolved branch present in ID this cycle
- upd_pc_i  in  XLEN  PC of resolved branch
- upd_taken_i  in  1  actual direction
- upd_target_i  in  XLEN  actual taken target
- upd_pred_taken_i  in  1  prediction made for this branch, carried through IF/ID
- upd_pred_target_i  in  XLEN  predicted target, carried through IF/ID
- mispredict_o  out  1  resolved branch was mispredicted
- redirect_pc_o  out  XLEN  correct next PC after the resolved branch
- branch_cnt_o  out  CNT_W  resolved-branch count
- mispred_cnt_o  out  CNT_W  misprediction count

## Operation
- Each entry holds valid, tag[TAG_W], ctr[CTR_W] and target[XLEN]. Index = pc[IDX_W+1:2].
- Lookup (combinational from current state): hit = valid & tag match.
  - pred_taken_o = hit & ctr[CTR_W-1].
  - pred_target_o = pred_taken_o ? target : if_pc_i+4.
- mispredict_o = upd_valid_i & ((upd_pred_taken_i≠upd_taken_i) | (upd_taken_i & upd_pred_target_i≠upd_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
- Update at the clock edge when upd_valid_i=1, indexed by upd_pc_i:
  - Hit: ctr increments on taken and decrements on not-taken, saturating at 0 and 2^CTR_W-1. If taken, target is written.
  - Miss, taken: the entry is allocated or overwritten with valid=1, the new tag, ctr=2^(CTR_W-1) (weakly taken) and target=upd_target_i.
  - Miss, not-taken: no change.
- Priority: reset > flush_i > update. flush_i clears every valid bit; counters and targets are retained but unused.
- Performance counters: branch_cnt_o increments on each upd_valid_i; mispred_cnt_o increments on each mispredict_o. Both saturate at all-ones and are not cleared by flush_i.
- All arithmetic (+4) wraps modulo 2^XLEN.

## Timing
- Lookup latency is 0 cycles; prediction is valid in the same cycle as if_pc_i.
- An update performed at edge N is visible to lookups from cycle N+1.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents.
- mispredict_o and redirect_pc_o are combinational in the upd_valid_i cycle. They are computed even during reset and flush; the state change is suppressed.
- Reset (rst_i=0 at an edge):
  - All valid bits cleared, every ctr=2^(CTR_W-1)-1 (weakly not-taken), every target=0, both counters 0.
  - Outputs after reset: pred_taken_o=0, pred_target_o=if_pc_i+4.
  - An update in a reset cycle is discarded.
- flush_i together with upd_valid_i: the flush wins and no allocation occurs; the performance counters still count.

## Configuration
- BRANCH_PREDICTOR_PERF_CNT_EN defined: branch_cnt_o and mispred_cnt_o are implemented as described.
- BRANCH_PREDICTOR_PERF_CNT_EN undefined: no counter registers are built and both outputs are tied to 0. Prediction behaviour is identical.

## Test plan
Defaults are used throughout.
- Reset, then lookup if_pc_i=0x40 -> pred_taken_o=0, pred_target_o=0x44, both counters 0.
- Update pc=0x40, taken, target=0x80, pred_taken=0 -> mispredict_o=1, redirect_pc_o=0x80. Next cycle, lookup 0x40 -> pred_taken_o=1, pred_target_o=0x80; mispred_cnt_o=1.
- Four not-taken updates to 0x40 after allocation -> ctr saturates at 0. Lookup gives pred_taken_o=0, pred_target_o=0x44. Five taken updates -> ctr=3 with no overflow.
- Aliasing: allocate 0x40, then taken update 0x440 (same index, different tag) -> entry replaced. Lookup 0x40 misses; lookup 0x440 predicts taken.
- Same-cycle lookup and update of 0x40 (allocation) -> that cycle pred_taken_o=0; the following cycle pred_taken_o=1.
- flush_i=1 with upd_valid_i taken -> next lookup misses and branch_cnt_o increments. rst_i=0 mid-stream -> all state at reset values on the next cycle.
